ecc_88_err_monitor: RTL and testbench
=====================================

ECC_88_ERR_MONITOR -- requirements
Module: ecc_88_err_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: width of the read address tagged to each checked word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of each saturating error counter.
REQ-003 SHALL have parameter SBIT_THRESH, default 16: single-bit count at which err_irq asserts.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port chk_vld, input, 1: one checked word is presented this cycle by the 88-bit ECC fault-detect stage.
REQ-007 SHALL have port chk_addr, input, ADDR_WIDTH: FIFO read address of that word.
REQ-008 SHALL have ports sbit_err, dbit_err and ecc_fault, input, 1 each: the checker's per-word result flags, qualified by chk_vld.
REQ-009 SHALL have port clr_req, input, 1: level request to clear all status.
REQ-010 SHALL have port clr_ack, output, 1: clear-done acknowledge.
REQ-011 SHALL have ports sbit_cnt, dbit_cnt and fault_cnt, output, CNT_WIDTH each: saturating event counts.
REQ-012 SHALL have port first_vld, output, 1: first-error record is valid.
REQ-013 SHALL have port first_addr, output, ADDR_WIDTH: address of the first logged error.
REQ-014 SHALL have port first_type, output, 2: type of the first logged error; 01 = sbit, 10 = dbit, 11 = fault.
REQ-015 SHALL have port err_irq, output, 1: sticky interrupt.

Function
REQ-016 SHALL register chk_vld, chk_addr and the three flags in a stage-1 register on every clk edge.
REQ-017 SHALL update counters and the first-error record from stage 1 on the next edge; latency is 2 edges from input to outputs.
REQ-018 SHALL treat a stage-1 word as an event only when chk_vld was 1; the flags are ignored otherwise.
REQ-019 SHALL count only dbit when sbit_err and dbit_err are both 1 in the same word.
REQ-020 SHALL count ecc_fault independently of sbit/dbit, so one word may increment both fault_cnt and dbit_cnt.
REQ-021 SHALL hold each counter at all-ones once it reaches all-ones; it never wraps.
REQ-022 SHALL load the first-error record (first_vld=1, first_addr, first_type) on the first event after reset or clear, and hold it until the next clear.
REQ-023 SHALL select first_type by priority fault > dbit > sbit when several flags are set in that word.
REQ-024 SHALL set err_irq on any dbit or fault event.
REQ-025 SHALL set err_irq when the post-update sbit_cnt is >= SBIT_THRESH.
REQ-026 SHALL keep err_irq asserted until a clear.
REQ-027 SHALL implement clear FSM state IDLE: clr_req=1 -> CLR.
REQ-028 SHALL implement clear FSM state CLR, lasting one cycle: zero all counters, first_vld, first_addr, first_type and err_irq, and discard any stage-1 event in that cycle; then -> ACK.
REQ-029 SHALL implement clear FSM state ACK: clr_ack=1; stay while clr_req=1; clr_req=0 -> IDLE with clr_ack=0.
REQ-030 SHALL keep logging events normally in ACK and IDLE.
REQ-031 SHALL do nothing further if clr_req drops during CLR; the FSM still passes through ACK for one cycle.
REQ-032 SHALL apply SBIT_THRESH=0 as irq on the first sbit event only; it SHALL NOT assert from reset.

Reset
REQ-033 SHALL asynchronously, on rst=1, drive all counters to 0, first_vld=0, first_addr=0, first_type=00, err_irq=0, clr_ack=0, stage-1 register to 0 and FSM to IDLE.
REQ-034 SHALL abort any clear in progress when rst asserts mid-clear, and return to IDLE with no clr_ack pulse owed.

Verification
REQ-035 SHALL cover: after reset, three chk_vld cycles with sbit_err=1 at addr 5,6,7 -> sbit_cnt=3 two edges after the last one, first_addr=5, first_type=01, err_irq=0.
REQ-036 SHALL cover: one word with sbit_err=dbit_err=ecc_fault=1 at addr 9 -> dbit_cnt=1, fault_cnt=1, sbit_cnt=0, first_type=11, err_irq=1.
REQ-037 SHALL cover: CNT_WIDTH=4, 20 dbit events -> dbit_cnt holds at 15.
REQ-038 SHALL cover: SBIT_THRESH=16, 16 sbit events -> err_irq rises exactly with sbit_cnt=16, not at 15.
REQ-039 SHALL cover: clr_req held 3 cycles with an event in the CLR cycle -> all status 0, that event uncounted, clr_ack high until clr_req falls.
REQ-040 SHALL cover: rst pulsed during ACK -> clr_ack=0 immediately (asynchronously) and FSM in IDLE.

Source files
------------

// File: rtl/ecc_88_err_monitor.sv
// ecc_88_err_monitor
// Collects the per-word result flags of the 88-bit ECC fault-detect stage.
// It keeps saturating event counters, a first-error record and a sticky
// interrupt. A request/acknowledge handshake clears all status.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   chk_vld    : a checked word is presented this cycle
//   chk_addr   : FIFO read address of that word
//   sbit_err   : single-bit error flag (qualified by chk_vld)
//   dbit_err   : double-bit error flag (qualified by chk_vld)
//   ecc_fault  : checker fault flag (qualified by chk_vld)
//   clr_req    : level request to clear all status
//   clr_ack    : clear done, held until clr_req falls
//   sbit_cnt   : saturating single-bit event count
//   dbit_cnt   : saturating double-bit event count
//   fault_cnt  : saturating fault event count
//   first_vld  : first-error record valid
//   first_addr : address of the first logged error
//   first_type : 01 sbit, 10 dbit, 11 fault
//   err_irq    : sticky interrupt
module ecc_88_err_monitor #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SBIT_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_vld,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  clr_req,
    output logic                  clr_ack,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic                  first_vld,
    output logic [ADDR_WIDTH-1:0] first_addr,
    output logic [1:0]            first_type,
    output logic                  err_irq
);

    // The threshold compare is done at least 32 bits wide so that a
    // threshold above the counter range can never be met.
    localparam int unsigned CMP_W = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] val,
        input logic                 en
    );
        if (en && (val != {CNT_WIDTH{1'b1}})) begin
            sat_inc = val + CNT_WIDTH'(1'b1);
        end else begin
            sat_inc = val;
        end
    endfunction

    // Error type code with priority fault > dbit > sbit.
    function automatic logic [1:0] err_type(
        input logic fault,
        input logic dbit
    );
        if (fault) begin
            err_type = 2'b11;
        end else if (dbit) begin
            err_type = 2'b10;
        end else begin
            err_type = 2'b01;
        end
    endfunction

    state_t                state_q, state_d;
    logic                  clr_ack_q, clr_ack_d;
    logic                  clr_active_s;

    logic                  s1_vld_q, s1_vld_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic                  s1_sbit_q, s1_sbit_d;
    logic                  s1_dbit_q, s1_dbit_d;
    logic                  s1_fault_q, s1_fault_d;

    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d;
    logic [CNT_WIDTH-1:0]  dbit_cnt_q, dbit_cnt_d;
    logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
    logic                  first_vld_q, first_vld_d;
    logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
    logic [1:0]            first_type_q, first_type_d;
    logic                  err_irq_q, err_irq_d;

    logic                  sbit_ev_s, dbit_ev_s, fault_ev_s, any_ev_s;
    logic                  sbit_over_s;

    // Stage-1 capture of the incoming word.
    always_comb begin
        s1_vld_d   = chk_vld;
        s1_addr_d  = chk_addr;
        s1_sbit_d  = sbit_err;
        s1_dbit_d  = dbit_err;
        s1_fault_d = ecc_fault;
    end

    // Stage-1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= {ADDR_WIDTH{1'b0}};
            s1_sbit_q  <= 1'b0;
            s1_dbit_q  <= 1'b0;
            s1_fault_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_sbit_q  <= s1_sbit_d;
            s1_dbit_q  <= s1_dbit_d;
            s1_fault_q <= s1_fault_d;
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear FSM next state; CLR always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (clr_req) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear FSM outputs; clr_ack is registered alongside the state it reflects.
    always_comb begin
        clr_active_s = (state_q == ST_CLR);
        clr_ack_d    = (state_d == ST_ACK);
    end

    // Acknowledge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_ack_q <= 1'b0;
        end else begin
            clr_ack_q <= clr_ack_d;
        end
    end

    // Event decode; a word with both sbit and dbit counts only as dbit.
    always_comb begin
        sbit_ev_s  = s1_vld_q & s1_sbit_q & ~s1_dbit_q;
        dbit_ev_s  = s1_vld_q & s1_dbit_q;
        fault_ev_s = s1_vld_q & s1_fault_q;
        any_ev_s   = sbit_ev_s | dbit_ev_s | fault_ev_s;
    end

    // Status update; the CLR cycle wipes status and drops the stage-1 word.
    always_comb begin
        sbit_cnt_d   = sbit_cnt_q;
        dbit_cnt_d   = dbit_cnt_q;
        fault_cnt_d  = fault_cnt_q;
        first_vld_d  = first_vld_q;
        first_addr_d = first_addr_q;
        first_type_d = first_type_q;
        err_irq_d    = err_irq_q;
        sbit_over_s  = 1'b0;
        if (clr_active_s) begin
            sbit_cnt_d   = {CNT_WIDTH{1'b0}};
            dbit_cnt_d   = {CNT_WIDTH{1'b0}};
            fault_cnt_d  = {CNT_WIDTH{1'b0}};
            first_vld_d  = 1'b0;
            first_addr_d = {ADDR_WIDTH{1'b0}};
            first_type_d = 2'b00;
            err_irq_d    = 1'b0;
        end else begin
            sbit_cnt_d  = sat_inc(sbit_cnt_q, sbit_ev_s);
            dbit_cnt_d  = sat_inc(dbit_cnt_q, dbit_ev_s);
            fault_cnt_d = sat_inc(fault_cnt_q, fault_ev_s);
            if (!first_vld_q && any_ev_s) begin
                first_vld_d  = 1'b1;
                first_addr_d = s1_addr_q;
                first_type_d = err_type(s1_fault_q, s1_dbit_q);
            end else begin
                first_vld_d  = first_vld_q;
                first_addr_d = first_addr_q;
                first_type_d = first_type_q;
            end
            // Gating with the sbit event keeps a zero threshold from
            // firing straight out of reset.
            sbit_over_s = sbit_ev_s &&
                          (CMP_W'(sbit_cnt_d) >= CMP_W'(SBIT_THRESH));
            err_irq_d   = err_irq_q | dbit_ev_s | fault_ev_s | sbit_over_s;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbit_cnt_q   <= {CNT_WIDTH{1'b0}};
            dbit_cnt_q   <= {CNT_WIDTH{1'b0}};
            fault_cnt_q  <= {CNT_WIDTH{1'b0}};
            first_vld_q  <= 1'b0;
            first_addr_q <= {ADDR_WIDTH{1'b0}};
            first_type_q <= 2'b00;
            err_irq_q    <= 1'b0;
        end else begin
            sbit_cnt_q   <= sbit_cnt_d;
            dbit_cnt_q   <= dbit_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
            first_vld_q  <= first_vld_d;
            first_addr_q <= first_addr_d;
            first_type_q <= first_type_d;
            err_irq_q    <= err_irq_d;
        end
    end

    assign clr_ack    = clr_ack_q;
    assign sbit_cnt   = sbit_cnt_q;
    assign dbit_cnt   = dbit_cnt_q;
    assign fault_cnt  = fault_cnt_q;
    assign first_vld  = first_vld_q;
    assign first_addr = first_addr_q;
    assign first_type = first_type_q;
    assign err_irq    = err_irq_q;

endmodule

// File: tb/tb_ecc_88_err_monitor.sv
// Bench for ecc_88_err_monitor. Three instances share the stimulus:
// default parameters, a 4-bit counter variant and a zero-threshold variant.
module tb_ecc_88_err_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_vld, sbit_err, dbit_err, ecc_fault, clr_req;
    logic [7:0] chk_addr;

    logic        ack0, fv0, irq0;
    logic [15:0] sb0, db0, fc0;
    logic [7:0]  fa0;
    logic [1:0]  ft0;
    logic        ack1, fv1, irq1;
    logic [3:0]  sb1, db1, fc1;
    logic [7:0]  fa1;
    logic [1:0]  ft1;
    logic        ack2, fv2, irq2;
    logic [15:0] sb2, db2, fc2;
    logic [7:0]  fa2;
    logic [1:0]  ft2;

    always #5 clk = ~clk;

    ecc_88_err_monitor #(.ADDR_WIDTH(8), .CNT_WIDTH(16), .SBIT_THRESH(16)) dut0 (
        .clk(clk), .rst(rst), .chk_vld(chk_vld), .chk_addr(chk_addr),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
        .clr_req(clr_req), .clr_ack(ack0), .sbit_cnt(sb0), .dbit_cnt(db0),
        .fault_cnt(fc0), .first_vld(fv0), .first_addr(fa0), .first_type(ft0),
        .err_irq(irq0));

    ecc_88_err_monitor #(.ADDR_WIDTH(8), .CNT_WIDTH(4), .SBIT_THRESH(16)) dut1 (
        .clk(clk), .rst(rst), .chk_vld(chk_vld), .chk_addr(chk_addr),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
        .clr_req(clr_req), .clr_ack(ack1), .sbit_cnt(sb1), .dbit_cnt(db1),
        .fault_cnt(fc1), .first_vld(fv1), .first_addr(fa1), .first_type(ft1),
        .err_irq(irq1));

    ecc_88_err_monitor #(.ADDR_WIDTH(8), .CNT_WIDTH(16), .SBIT_THRESH(0)) dut2 (
        .clk(clk), .rst(rst), .chk_vld(chk_vld), .chk_addr(chk_addr),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
        .clr_req(clr_req), .clr_ack(ack2), .sbit_cnt(sb2), .dbit_cnt(db2),
        .fault_cnt(fc2), .first_vld(fv2), .first_addr(fa2), .first_type(ft2),
        .err_irq(irq2));

    typedef struct packed {
        logic        ack;
        logic [15:0] sb;
        logic [15:0] db;
        logic [15:0] fc;
        logic        fv;
        logic [7:0]  fa;
        logic [1:0]  ft;
        logic        irq;
    } rec_t;

    typedef struct packed {
        rec_t r0;
        rec_t r1;
        rec_t r2;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state (index 0/1/2 = dut0/dut1/dut2)
    int         m_st;
    logic       m_v, m_s, m_d, m_f;
    logic [7:0] m_a;
    int         m_sb[3], m_db[3], m_fc[3];
    logic       m_fv[3], m_irq[3];
    logic [7:0] m_fa[3];
    logic [1:0] m_ft[3];

    function automatic int cmax(int k);
        return (k == 1) ? 15 : 65535;
    endfunction

    function automatic int cthr(int k);
        return (k == 2) ? 0 : 16;
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_v = 1'b0; m_s = 1'b0; m_d = 1'b0; m_f = 1'b0; m_a = 8'd0;
        for (int k = 0; k < 3; k++) begin
            m_sb[k] = 0; m_db[k] = 0; m_fc[k] = 0;
            m_fv[k] = 1'b0; m_fa[k] = 8'd0; m_ft[k] = 2'b00; m_irq[k] = 1'b0;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Advances the model by one rising edge with the given inputs present.
    task automatic model_edge(input logic v, input logic [7:0] a,
                              input logic s, input logic d, input logic f,
                              input logic c);
        logic sev, dev, fev;
        sev = m_v && m_s && !m_d;
        dev = m_v && m_d;
        fev = m_v && m_f;
        for (int k = 0; k < 3; k++) begin
            if (m_st == 1) begin
                m_sb[k] = 0; m_db[k] = 0; m_fc[k] = 0;
                m_fv[k] = 1'b0; m_fa[k] = 8'd0; m_ft[k] = 2'b00; m_irq[k] = 1'b0;
            end else begin
                if (sev && m_sb[k] < cmax(k)) m_sb[k] = m_sb[k] + 1;
                if (dev && m_db[k] < cmax(k)) m_db[k] = m_db[k] + 1;
                if (fev && m_fc[k] < cmax(k)) m_fc[k] = m_fc[k] + 1;
                if (!m_fv[k] && (sev || dev || fev)) begin
                    m_fv[k] = 1'b1;
                    m_fa[k] = m_a;
                    m_ft[k] = fev ? 2'b11 : (dev ? 2'b10 : 2'b01);
                end
                if (dev || fev || (sev && m_sb[k] >= cthr(k))) m_irq[k] = 1'b1;
            end
        end
        m_v = v; m_a = a; m_s = s; m_d = d; m_f = f;
        case (m_st)
            0:       m_st = c ? 1 : 0;
            1:       m_st = 2;
            default: m_st = c ? 2 : 0;
        endcase
    endtask

    function automatic snap_t model_snap();
        rec_t  r[3];
        snap_t s;
        for (int k = 0; k < 3; k++) begin
            r[k].ack = (m_st == 2);
            r[k].sb  = 16'(m_sb[k]);
            r[k].db  = 16'(m_db[k]);
            r[k].fc  = 16'(m_fc[k]);
            r[k].fv  = m_fv[k];
            r[k].fa  = m_fa[k];
            r[k].ft  = m_ft[k];
            r[k].irq = m_irq[k];
        end
        s.r0 = r[0]; s.r1 = r[1]; s.r2 = r[2];
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.r0 = '{ack0, sb0, db0, fc0, fv0, fa0, ft0, irq0};
        s.r1 = '{ack1, {12'd0, sb1}, {12'd0, db1}, {12'd0, fc1}, fv1, fa1, ft1, irq1};
        s.r2 = '{ack2, sb2, db2, fc2, fv2, fa2, ft2, irq2};
        return s;
    endfunction

    // One clock: drive, push expected, sample output after the edge.
    task automatic step(input logic v, input logic [7:0] a, input logic s,
                        input logic d, input logic f, input logic c);
        @(negedge clk);
        chk_vld = v; chk_addr = a; sbit_err = s; dbit_err = d; ecc_fault = f;
        clr_req = c;
        model_edge(v, a, s, d, f, c);
        exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        obs_q.push_back(dut_snap());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        chk_vld = 1'b0; chk_addr = 8'd0; sbit_err = 1'b0; dbit_err = 1'b0;
        ecc_fault = 1'b0; clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o;
        rst = 1'b1;
        chk_vld = 1'b1; chk_addr = 8'hAA; sbit_err = 1'b1; dbit_err = 1'b1;
        ecc_fault = 1'b1; clr_req = 1'b1;
        #3;
        o = dut_snap();
        checks++;
        if (o !== snap_t'(0)) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", o);
        end
        do_reset();
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e, q;
            e = exp_q.pop_front(); q = obs_q.pop_front();
            checks++;
            if (q !== e) begin
                failures++;
                $display("FAIL reset_idle: got %h want %h", q, e);
            end
        end
    endtask

    task automatic test_sbit_basic();
        int idx = 0;
        do_reset();
        step(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sbit_basic[%0d]: got %h want %h", idx, o, e);
            end
            if (idx == 2) begin
                checks++;
                if (o.r0.sb !== 16'd2) begin
                    failures++;
                    $display("FAIL sbit_latency: sbit_cnt=%0d want 2", o.r0.sb);
                end
            end
            if (idx == 3) begin
                checks++;
                if (o.r0.sb !== 16'd3 || o.r0.fa !== 8'd5 || o.r0.ft !== 2'b01 ||
                    o.r0.irq !== 1'b0) begin
                    failures++;
                    $display("FAIL sbit_final: cnt=%0d addr=%0d type=%b irq=%b want 3 5 01 0",
                             o.r0.sb, o.r0.fa, o.r0.ft, o.r0.irq);
                end
            end
            idx++;
        end
    endtask

    task automatic test_multi_flag();
        snap_t o;
        do_reset();
        step(1'b1, 8'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL multi_flag: got %h want %h", o, e);
            end
        end
        checks++;
        if (o.r0.db !== 16'd1 || o.r0.fc !== 16'd1 || o.r0.sb !== 16'd0 ||
            o.r0.ft !== 2'b11 || o.r0.fa !== 8'd9 || o.r0.irq !== 1'b1) begin
            failures++;
            $display("FAIL multi_flag_final: db=%0d fc=%0d sb=%0d type=%b irq=%b want 1 1 0 11 1",
                     o.r0.db, o.r0.fc, o.r0.sb, o.r0.ft, o.r0.irq);
        end
    endtask

    task automatic test_saturate();
        snap_t o;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 32), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL saturate: got %h want %h", o, e);
            end
        end
        checks++;
        if (o.r1.db !== 16'd15 || o.r0.db !== 16'd20) begin
            failures++;
            $display("FAIL saturate_final: w4 dbit=%0d w16 dbit=%0d want 15 20",
                     o.r1.db, o.r0.db);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 64), 1'b1, 1'b0, 1'b0, 1'b0);
            // unqualified flags must be ignored
            step(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        idle(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL threshold: got %h want %h", o, e);
            end
            if (o.r0.sb == 16'd15) begin
                checks++;
                if (o.r0.irq !== 1'b0) begin
                    failures++;
                    $display("FAIL thresh_15: irq=%b want 0", o.r0.irq);
                end
            end
            if (o.r0.sb == 16'd16) begin
                checks++;
                if (o.r0.irq !== 1'b1) begin
                    failures++;
                    $display("FAIL thresh_16: irq=%b want 1", o.r0.irq);
                end
            end
            if (o.r2.sb == 16'd0) begin
                checks++;
                if (o.r2.irq !== 1'b0) begin
                    failures++;
                    $display("FAIL thresh0_idle: irq=%b want 0", o.r2.irq);
                end
            end
        end
    endtask

    task automatic test_clear();
        snap_t o;
        do_reset();
        step(1'b1, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'd21, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // event word captured with the request; it sits in stage 1 during CLR
        step(1'b1, 8'd22, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL clear: got %h want %h", o, e);
            end
        end
        checks++;
        if (o.r0 !== rec_t'(0)) begin
            failures++;
            $display("FAIL clear_final: got %h want 0", o.r0);
        end
        // request dropped during CLR, then logging restarts with a new first record
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL clear_short: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_rst_during_ack();
        snap_t o;
        do_reset();
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pre_rst_ack: got %h want %h", o, e);
            end
        end
        // mid-cycle reset while acknowledging
        rst = 1'b1;
        clr_req = 1'b0;
        #1;
        o = dut_snap();
        checks++;
        if (o !== snap_t'(0)) begin
            failures++;
            $display("FAIL rst_in_ack: got %h want 0", o);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL post_rst_idle: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0),
                 1'($urandom_range(7, 0) == 0), 1'($urandom_range(11, 0) == 0));
        end
        idle(3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            snap_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back: got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_sbit_basic();
        test_multi_flag();
        test_saturate();
        test_threshold();
        test_clear();
        test_rst_during_ack();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
